// File: rtl/delay_tap_ctrl.sv
// Tap-select sequencer for a 3-stage tapped delay line: accepts tap changes over
// valid/ready, applies them as a jump or a tap-by-tap walk, and qualifies the tap data.
module delay_tap_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       flush,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_tap,
  input  logic       cfg_step,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic {IDLE, SETTLE} state_e;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       target_q, target_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       vld_q, vld_d;
  logic             tap_vld;

  // sel never wraps: moving toward the target is always +1 or -1.
  function automatic logic [1:0] step_toward(input logic [1:0] cur, input logic [1:0] tgt);
    return (tgt > cur) ? cur + 2'd1 : cur - 2'd1;
  endfunction

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    target_d = target_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    vld_d    = flush ? 3'b000 : {vld_q[1:0], in_valid};

    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          target_d = cfg_tap;
          mode_d   = cfg_step;
          if (cfg_tap != sel_q) begin
            sel_d   = cfg_step ? step_toward(sel_q, cfg_tap) : cfg_tap;
            cnt_d   = CNT_RELOAD;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if ((sel_q == target_q) || !mode_q) begin
          state_d = IDLE;
        end else begin
          sel_d = step_toward(sel_q, target_q);
          cnt_d = CNT_RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      target_q <= 2'd0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      vld_q    <= 3'b000;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
    end
  end

  // Bypass tap carries the live input valid; stage taps carry the tracked bits.
  always_comb begin
    tap_vld = in_valid;
    unique case (sel_q)
      2'd0:    tap_vld = in_valid;
      2'd1:    tap_vld = vld_q[0];
      2'd2:    tap_vld = vld_q[1];
      default: tap_vld = vld_q[2];
    endcase
  end

  assign sel       = sel_q;
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == IDLE) & tap_vld;

endmodule
